// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: decodes the opcode into datapath controls, stalls on mem_ready/io_ack.
// Outputs are combinational from the state (plus mem_ready/io_ack gating); no backpressure beyond those stalls.
module multicycle_control_unit (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] ir_op,
   input  logic       zero,
   input  logic       mem_ready,
   input  logic       io_ack,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemtoReg,
   output logic       io_req,
   output logic       io_we,
   output logic       halted,
   output logic       io_timeout,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_ALU_EX   = 4'd2,
      S_ALU_WB   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_IO_WAIT  = 4'd10,
      S_HALT     = 4'd11
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tmo_q, tmo_d;
   logic       out_we;

   // The branch condition (PCWriteCond & zero) is resolved in the datapath.
   logic unused_zero;
   assign unused_zero = zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         op_q    <= 3'b000;
         cnt_q   <= 8'd0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      out_we      = (op_q == 3'b110);
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = 1'b0;
      io_req      = 1'b0;
      io_we       = 1'b0;
      halted      = 1'b0;
      io_timeout  = tmo_q;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            PCWrite = mem_ready;
            IRWrite = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (ir_op)
               3'b000:         state_d = S_ALU_EX;
               3'b001, 3'b010: state_d = S_MEM_ADDR;
               3'b011:         state_d = S_BRANCH;
               3'b100:         state_d = S_JUMP;
               3'b101, 3'b110: begin
                  state_d = S_IO_WAIT;
                  op_d    = ir_op;
                  cnt_d   = 8'd0;
               end
               default:        state_d = S_HALT;
            endcase
         end
         S_ALU_EX: begin
            ALUSrcA = 2'b01;
            ALUOp   = 2'b10;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            state_d = (ir_op == 3'b001) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 2'b01;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            state_d  = S_FETCH;
         end
         S_IO_WAIT: begin
            io_req   = 1'b1;
            io_we    = out_we;
            MemtoReg = 1'b1;
            RegWrite = io_ack & ~out_we;
            // An ack arriving on the final count wins over the timeout.
            if (io_ack) begin
               state_d = S_FETCH;
            end else if (cnt_q == 8'hFF) begin
               tmo_d   = 1'b1;
               state_d = S_FETCH;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            io_timeout = 1'b0;
            state_d    = S_FETCH;
         end
      endcase

      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemtoReg    = 1'b0;
         io_req      = 1'b0;
         io_we       = 1'b0;
         halted      = 1'b0;
         io_timeout  = 1'b0;
         ALUSrcA     = 2'b00;
         ALUSrcB     = 2'b00;
         ALUOp       = 2'b00;
         PCSource    = 2'b00;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: each cycle's expected state/control vector is queued; a negedge monitor pops and compares.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [3:0] st;
      logic pcw, pcwc, iord, mrd, mwr, irw, rw, m2r, ioreq, iowe, hlt, tmo;
      logic [1:0] asa, asb, aop, pcs;
   } vec_t;

   localparam vec_t V_ZERO     = '{default: 0};
   localparam vec_t V_FETCH_W  = '{st: 4'd0, mrd: 1'b1, asb: 2'b01, default: 0};
   localparam vec_t V_FETCH_R  = '{st: 4'd0, mrd: 1'b1, asb: 2'b01, pcw: 1'b1, irw: 1'b1, default: 0};
   localparam vec_t V_DEC      = '{st: 4'd1, asb: 2'b11, default: 0};
   localparam vec_t V_ALUEX    = '{st: 4'd2, asa: 2'b01, aop: 2'b10, default: 0};
   localparam vec_t V_ALUWB    = '{st: 4'd3, rw: 1'b1, default: 0};
   localparam vec_t V_MADDR    = '{st: 4'd4, asa: 2'b01, asb: 2'b10, default: 0};
   localparam vec_t V_MRD      = '{st: 4'd5, mrd: 1'b1, iord: 1'b1, default: 0};
   localparam vec_t V_MWB      = '{st: 4'd6, rw: 1'b1, m2r: 1'b1, default: 0};
   localparam vec_t V_MWR      = '{st: 4'd7, mwr: 1'b1, iord: 1'b1, default: 0};
   localparam vec_t V_BR       = '{st: 4'd8, asa: 2'b01, aop: 2'b01, pcwc: 1'b1, pcs: 2'b01, default: 0};
   localparam vec_t V_JMP      = '{st: 4'd9, pcw: 1'b1, pcs: 2'b10, default: 0};
   localparam vec_t V_IOIN     = '{st: 4'd10, ioreq: 1'b1, m2r: 1'b1, default: 0};
   localparam vec_t V_IOIN_ACK = '{st: 4'd10, ioreq: 1'b1, m2r: 1'b1, rw: 1'b1, default: 0};
   localparam vec_t V_IOOUT    = '{st: 4'd10, ioreq: 1'b1, iowe: 1'b1, m2r: 1'b1, default: 0};
   localparam vec_t V_HALT     = '{st: 4'd11, hlt: 1'b1, default: 0};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] ir_op;
   logic       zero, mem_ready, io_ack;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, MemtoReg;
   logic       io_req, io_we, halted, io_timeout;
   logic [1:0] ALUSrcA, ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;

   int    checks = 0;
   int    failures = 0;
   logic  tmo_exp = 1'b0;
   vec_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .ir_op(ir_op), .zero(zero), .mem_ready(mem_ready), .io_ack(io_ack),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
      .io_req(io_req), .io_we(io_we), .halted(halted), .io_timeout(io_timeout),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state)
   );

   // Monitor: the DUT presents a control vector every cycle; compare it mid-cycle.
   always @(negedge clk) begin
      vec_t  act, e;
      string n;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n = name_q.pop_front();
         act = '{st: state, pcw: PCWrite, pcwc: PCWriteCond, iord: IorD, mrd: MemRead,
                 mwr: MemWrite, irw: IRWrite, rw: RegWrite, m2r: MemtoReg, ioreq: io_req,
                 iowe: io_we, hlt: halted, tmo: io_timeout, asa: ALUSrcA, asb: ALUSrcB,
                 aop: ALUOp, pcs: PCSource};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h required %h", n, act, e);
         end
      end
   end

   task automatic cyc(input logic mr, input logic ack, input vec_t v, input string name);
      vec_t e;
      mem_ready = mr;
      io_ack    = ack;
      e = v;
      if (e != V_ZERO) e.tmo = tmo_exp;
      exp_q.push_back(e);
      name_q.push_back(name);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ir_op = 3'b000; zero = 1'b0; mem_ready = 1'b1; io_ack = 1'b1;
      @(posedge clk); #1;
      cyc(1, 1, V_ZERO, "reset_outputs");
      rst_n = 1'b1;

      // R-type, with one fetch wait first
      ir_op = 3'b000;
      cyc(0, 0, V_FETCH_W, "fetch_wait");
      cyc(1, 0, V_FETCH_R, "rtype_fetch");
      cyc(1, 0, V_DEC,     "rtype_decode");
      cyc(1, 0, V_ALUEX,   "rtype_aluex");
      cyc(1, 0, V_ALUWB,   "rtype_aluwb");

      // load: MEM_RD held 4 cycles
      ir_op = 3'b001;
      cyc(1, 0, V_FETCH_R, "load_fetch");
      cyc(1, 0, V_DEC,     "load_decode");
      cyc(0, 0, V_MADDR,   "load_addr");
      for (int i = 0; i < 3; i++) cyc(0, 0, V_MRD, "load_rd_wait");
      cyc(1, 0, V_MRD,     "load_rd_done");
      cyc(0, 0, V_MWB,     "load_wb");

      // store with one wait
      ir_op = 3'b010;
      cyc(1, 0, V_FETCH_R, "store_fetch");
      cyc(1, 0, V_DEC,     "store_decode");
      cyc(1, 0, V_MADDR,   "store_addr");
      cyc(0, 0, V_MWR,     "store_wait");
      cyc(1, 0, V_MWR,     "store_done");

      ir_op = 3'b011;
      cyc(1, 0, V_FETCH_R, "br_fetch");
      cyc(1, 0, V_DEC,     "br_decode");
      cyc(1, 1, V_BR,      "br_exec");

      ir_op = 3'b100;
      cyc(1, 0, V_FETCH_R, "jmp_fetch");
      cyc(1, 0, V_DEC,     "jmp_decode");
      cyc(1, 0, V_JMP,     "jmp_exec");

      // IN: ack after 5 cycles; ir_op changed mid-wait must not set io_we
      ir_op = 3'b101;
      cyc(1, 0, V_FETCH_R, "in_fetch");
      cyc(1, 0, V_DEC,     "in_decode");
      ir_op = 3'b110;
      for (int i = 0; i < 5; i++) cyc(1, 0, V_IOIN, "in_wait");
      cyc(1, 1, V_IOIN_ACK, "in_ack");

      // IN: ack on count 255 beats the timeout
      ir_op = 3'b101;
      cyc(1, 0, V_FETCH_R, "inlate_fetch");
      cyc(1, 0, V_DEC,     "inlate_decode");
      for (int i = 0; i < 255; i++) cyc(0, 0, V_IOIN, "inlate_wait");
      cyc(0, 1, V_IOIN_ACK, "inlate_ack");

      // OUT: never acked, times out after 256 cycles
      ir_op = 3'b110;
      cyc(1, 0, V_FETCH_R, "out_fetch");
      cyc(1, 0, V_DEC,     "out_decode");
      ir_op = 3'b101;
      for (int i = 0; i < 256; i++) cyc(0, 0, V_IOOUT, "out_wait");
      tmo_exp = 1'b1;
      ir_op = 3'b000;
      cyc(1, 0, V_FETCH_R, "out_timeout_fetch");
      cyc(1, 0, V_DEC,     "sticky_decode");
      cyc(1, 0, V_ALUEX,   "sticky_aluex");
      cyc(1, 0, V_ALUWB,   "sticky_aluwb");

      // HALT held 20 cycles regardless of handshakes, then reset
      ir_op = 3'b111;
      cyc(1, 0, V_FETCH_R, "halt_fetch");
      cyc(1, 0, V_DEC,     "halt_decode");
      for (int i = 0; i < 20; i++) cyc(1, 1, V_HALT, "halt_hold");
      rst_n = 1'b0;
      tmo_exp = 1'b0;
      cyc(1, 1, V_ZERO, "halt_reset");
      cyc(1, 1, V_ZERO, "halt_reset_hold");
      rst_n = 1'b1;
      ir_op = 3'b000;
      cyc(1, 0, V_FETCH_R, "resume_fetch");
      cyc(1, 0, V_DEC,     "resume_decode");
      cyc(1, 0, V_ALUEX,   "resume_aluex");
      cyc(1, 0, V_ALUWB,   "resume_aluwb");

      // reset in the middle of an IN wait
      ir_op = 3'b101;
      cyc(1, 0, V_FETCH_R, "iorst_fetch");
      cyc(1, 0, V_DEC,     "iorst_decode");
      cyc(1, 0, V_IOIN,    "iorst_wait");
      rst_n = 1'b0;
      cyc(1, 1, V_ZERO,    "iorst_reset");
      rst_n = 1'b1;
      cyc(0, 1, V_FETCH_W, "iorst_resume");

      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
